add_32: RTL and testbench

ADD_32 -- requirements
Module: add_32

---
 rtl/add_32_pkg.sv | 7 +
 rtl/add_32_cells.sv | 50 +++++
 rtl/add_32.sv | 75 +++++++
 tb/tb_add_32.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/add_32_pkg.sv
// add_32_pkg: shared constants for the add_32 ripple-carry adder slice.
// Holds only the default operand/result width.
package add_32_pkg;

  localparam int ADD_32_WIDTH = 32;

endpackage : add_32_pkg

// File: rtl/add_32_cells.sv
// Leaf arithmetic cells for the add_32 ripple chain.
//   half_adder : a, b        -> sum = a ^ b, carry = a & b
//   adder      : a, b, c     -> full adder built from two half adders;
//                               carry = carry of first | carry of second
// Both are purely combinational and usable on their own.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder

module adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic ab_sum_s;
  logic ab_carry_s;
  logic abc_carry_s;

  // First stage adds the operands, second folds in the incoming carry.
  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (ab_sum_s),
    .carry (ab_carry_s)
  );

  half_adder u_ha_c (
    .a     (ab_sum_s),
    .b     (c),
    .sum   (sum),
    .carry (abc_carry_s)
  );

  // The two half-adder carries can never both be 1, so OR equals the
  // textbook (x & y) | (c & (x ^ y)).
  assign carry = ab_carry_s | abc_carry_s;

endmodule : adder

// File: rtl/add_32.sv
// add_32: WIDTH-bit ripple-carry adder with an enabled result register.
// Ports:
//   clk     - rising-edge clock for the result register
//   rst_n   - asynchronous active-low reset (clears registered outputs only)
//   a, b    - unsigned operands
//   cin     - carry into bit 0
//   en      - capture enable for the result register
//   out     - combinational (a + b + cin) mod 2^WIDTH
//   cout    - combinational carry out of bit WIDTH-1
//   out_q   - registered copy of out
//   cout_q  - registered copy of cout
//   valid_q - high once out_q/cout_q hold a captured result
module add_32
  import add_32_pkg::*;
#(
  parameter int WIDTH = ADD_32_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [WIDTH-1:0] out_q,
  output logic             cout_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] sum_s;

  // Ripple chain: each cell keeps its own carry nets so the chain is a
  // sequence of distinct signals rather than one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic carry_in_s;
    logic carry_out_s;

    if (i == 0) begin : g_first
      assign carry_in_s = cin;
    end else begin : g_rest
      assign carry_in_s = g_bit[i-1].carry_out_s;
    end

    adder u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c     (carry_in_s),
      .sum   (sum_s[i]),
      .carry (carry_out_s)
    );
  end

  assign out  = sum_s;
  assign cout = g_bit[WIDTH-1].carry_out_s;

  // Result register: capture on enabled edges, hold otherwise; reset drops
  // any held result without touching the combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      cout_q  <= cout;
      valid_q <= 1'b1;
    end else begin
      out_q   <= out_q;
      cout_q  <= cout_q;
      valid_q <= valid_q;
    end
  end

endmodule : add_32

// File: tb/tb_add_32.sv
// tb_add_32: self-checking bench for add_32 and its leaf cells.
// Combinational results are checked directly against plain integer
// arithmetic; registered results go through a scoreboard queue that a
// separate monitor drains after every enabled clock edge.
module tb_add_32;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          en;
  logic [W-1:0]  out;
  logic          cout;
  logic [W-1:0]  out_q;
  logic          cout_q;
  logic          valid_q;

  logic ha_a, ha_b, ha_sum, ha_carry;
  logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

  int total;
  int bad;

  // Scoreboard: expected {cout, out} for each enabled edge, plus the
  // bench's view of what the register currently holds.
  logic [W:0] exp_q[$];
  logic [W:0] model_reg;
  logic       model_valid;

  add_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .en      (en),
    .out     (out),
    .cout    (cout),
    .out_q   (out_q),
    .cout_q  (cout_q),
    .valid_q (valid_q)
  );

  half_adder u_ha (.a(ha_a), .b(ha_b), .sum(ha_sum), .carry(ha_carry));
  adder      u_fa (.a(fa_a), .b(fa_b), .c(fa_c), .sum(fa_sum), .carry(fa_carry));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint unsigned s;
    s = longint'(x) + longint'(y) + longint'(c);
    return s[W:0];
  endfunction

  task automatic comb_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    a = x; b = y; cin = c;
    #10;
    e = ref_sum(x, y, c);
    check({name, ".out"},  64'(out),  64'(e[W-1:0]));
    check({name, ".cout"}, 64'(cout), 64'(e[W]));
  endtask

  // Issue one cycle of stimulus at the falling edge; enabled cycles push
  // their expected result for the monitor.
  task automatic drive_cycle(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic e);
    @(negedge clk);
    a = x; b = y; cin = c; en = e;
    if (e && rst_n) exp_q.push_back(ref_sum(x, y, c));
  endtask

  // Monitor: after every edge, retire a scoreboard entry if that edge was
  // enabled, then compare the register outputs with the bench's model.
  initial begin
    logic cap;
    forever begin
      @(posedge clk);
      cap = en && rst_n;
      #1;
      if (cap) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          model_reg   = exp_q.pop_front();
          model_valid = 1'b1;
        end
      end
      check("mon.out_q",   64'(out_q),   64'(model_reg[W-1:0]));
      check("mon.cout_q",  64'(cout_q),  64'(model_reg[W]));
      check("mon.valid_q", 64'(valid_q), 64'(model_valid));
    end
  end

  initial begin
    logic [W-1:0] hold_out;
    logic [W:0]   cc;
    int           budget;
    total = 0; bad = 0;
    model_reg = '0; model_valid = 1'b0;
    rst_n = 1'b0; en = 1'b0; a = '0; b = '0; cin = 1'b0;
    ha_a = 1'b0; ha_b = 1'b0; fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0;
    #1;
    check("reset.out_q",   64'(out_q),   64'd0);
    check("reset.cout_q",  64'(cout_q),  64'd0);
    check("reset.valid_q", 64'(valid_q), 64'd0);

    // Leaf cells, exhaustive.
    for (int i = 0; i < 4; i++) begin
      ha_a = i[1]; ha_b = i[0];
      #1;
      check("half_adder.sum",   64'(ha_sum),   64'(i[1] ^ i[0]));
      check("half_adder.carry", 64'(ha_carry), 64'(i[1] & i[0]));
    end
    for (int i = 0; i < 8; i++) begin
      int ones;
      fa_a = i[2]; fa_b = i[1]; fa_c = i[0];
      ones = i[2] + i[1] + i[0];
      #1;
      check("adder.sum",   64'(fa_sum),   64'(ones % 2));
      check("adder.carry", 64'(fa_carry), 64'(ones >= 2 ? 1 : 0));
    end

    // Directed combinational corners.
    comb_check("alt_c0",   32'h55555555, 32'hAAAAAAAA, 1'b0);
    comb_check("alt_c1",   32'h55555555, 32'hAAAAAAAA, 1'b1);
    comb_check("ripple",   32'hFFFFFFFF, 32'h00000001, 1'b0);
    comb_check("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    comb_check("zero",     32'h00000000, 32'h00000000, 1'b0);

    // Release reset while the clock is low.
    @(negedge clk);
    rst_n = 1'b1;

    // 3 + 4 captured, then held while a changes.
    drive_cycle(32'd3, 32'd4, 1'b0, 1'b1);
    drive_cycle(32'd9, 32'd4, 1'b0, 1'b0);
    #10;
    check("hold.out_q", 64'(out_q), 64'd7);
    check("hold.out",   64'(out),   64'd13);
    drive_cycle(32'd100, 32'd4, 1'b0, 1'b0);

    // Reset pulse between edges: registers clear at once, sum untouched.
    #5;
    hold_out = out;
    rst_n = 1'b0;
    #1;
    check("arst.out_q",   64'(out_q),   64'd0);
    check("arst.cout_q",  64'(cout_q),  64'd0);
    check("arst.valid_q", 64'(valid_q), 64'd0);
    check("arst.out",     64'(out),     64'(hold_out));
    model_reg = '0; model_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    drive_cycle(32'd1, 32'd1, 1'b0, 1'b0);

    // Random traffic: combinational check mid-cycle, register via scoreboard.
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] ra, rb;
      logic rc, re;
      ra = $urandom();
      rb = (n % 10 == 0) ? ~ra : W'($urandom());
      rc = 1'($urandom());
      re = ($urandom_range(0, 3) != 0);
      drive_cycle(ra, rb, rc, re);
      #10;
      cc = ref_sum(ra, rb, rc);
      check("rand.out",  64'(out),  64'(cc[W-1:0]));
      check("rand.cout", 64'(cout), 64'(cc[W]));
    end

    @(negedge clk);
    en = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_add_32
